// File: rtl/r_alu_pipe.sv
// Two-stage pipelined RV32I R-type ALU with valid/ready handshakes on both sides.
// Define R_ALU_SHIFT_EN to build the SLL/SRL/SRA shifter; otherwise those encodings report illegal.
`timescale 1ns/1ps

module r_alu_pipe #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             illegal
);

    // Handshake: a transfer happens on any edge where valid && ready; a
    // producer holds its payload stable until that edge.
    logic             s1_valid_q, s1_valid_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] x_q, y_q;
    logic [2:0]       f3_q;
    logic [6:0]       f7_q;
    logic [WIDTH-1:0] result_q;
    logic             illegal_q;

    logic             s2_advance;
    logic             s2_load;
    logic             in_fire;
    logic             f7_alt;
    logic             legal;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;

    assign s2_advance = !s2_valid_q || out_ready;
    assign s2_load    = s2_advance && s1_valid_q;
    assign in_ready   = !s1_valid_q || s2_advance;
    assign in_fire    = in_valid && in_ready;

    assign out_valid  = s2_valid_q;
    assign result     = result_q;
    assign illegal    = illegal_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
        end else if (s2_advance) begin
            s1_valid_d = 1'b0;
        end
        if (s2_advance) begin
            s2_valid_d = s1_valid_q;
        end
    end

`ifdef R_ALU_SHIFT_EN
    logic [SHW-1:0] shamt;
    assign shamt = y_q[SHW-1:0];
`endif

    assign f7_alt = (f7_q == 7'b0100000);
    assign legal  = (f7_q == 7'b0000000) || (f7_alt && (f3_q == 3'b000 || f3_q == 3'b101));

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        if (!legal) begin
            alu_ill = 1'b1;
        end else begin
            unique case (f3_q)
                3'b000: alu_res = f7_alt ? (x_q - y_q) : (x_q + y_q);
`ifdef R_ALU_SHIFT_EN
                3'b001: alu_res = x_q << shamt;
                3'b101: alu_res = f7_alt ? $unsigned($signed(x_q) >>> shamt) : (x_q >> shamt);
`else
                3'b001, 3'b101: alu_ill = 1'b1;
`endif
                3'b010: alu_res = {{(WIDTH-1){1'b0}}, ($signed(x_q) < $signed(y_q))};
                3'b011: alu_res = {{(WIDTH-1){1'b0}}, (x_q < y_q)};
                3'b100: alu_res = x_q ^ y_q;
                3'b110: alu_res = x_q | y_q;
                3'b111: alu_res = x_q & y_q;
                default: alu_res = '0;
            endcase
        end
    end

    // Reset wins over any simultaneous transfer and discards in-flight work.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            f3_q       <= '0;
            f7_q       <= '0;
            result_q   <= '0;
            illegal_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (in_fire) begin
                x_q  <= X;
                y_q  <= Y;
                f3_q <= funct3;
                f7_q <= funct7;
            end
            if (s2_load) begin
                result_q  <= alu_res;
                illegal_q <= alu_ill;
            end
        end
    end

endmodule

// File: tb/tb_r_alu_pipe.sv
// Bench for r_alu_pipe: directed cases plus random traffic against an arithmetic reference model.
// Shift expectations follow R_ALU_SHIFT_EN the same way the design does.
`timescale 1ns/1ps

module tb_r_alu_pipe;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic [2:0]   funct3;
    logic [6:0]   funct7;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         illegal;

    always #5 clk = ~clk;

    r_alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .X(X), .Y(Y), .funct3(funct3), .funct7(funct7),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .illegal(illegal)
    );

    // Scoreboard: expected results in issue order, with the edge each op was accepted on.
    logic [W-1:0] exp_q[$];
    logic         ill_q[$];
    int           acc_q[$];

    int           errors = 0;
    int           checks = 0;
    int           edge_cnt = 0;
    bit           last_fire;
    bit           ovr = 1'b0;
    logic [W-1:0] ovr_res;
    logic         ovr_ill;
    bit           stall_prev = 1'b0;
    logic [W-1:0] held_res;
    logic         held_ill;

    function automatic logic [W:0] model(logic [W-1:0] x, logic [W-1:0] y,
                                         logic [2:0] f3, logic [6:0] f7);
        logic [W-1:0] ones;
        logic [W-1:0] msb;
        logic [W-1:0] r;
        int           sh;
        bit           ok;
        ones = '1;
        msb  = ones ^ (ones >> 1);
        sh   = int'(y % W);
        ok   = (f7 == 7'd0) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
`ifndef R_ALU_SHIFT_EN
        if (f3 == 3'd1 || f3 == 3'd5) ok = 1'b0;
`endif
        if (!ok) return {1'b1, {W{1'b0}}};
        case (f3)
            3'd0: r = (f7 == 7'h20) ? x - y : x + y;
            3'd1: r = x << sh;
            3'd2: r = ((x ^ msb) < (y ^ msb)) ? W'(1) : W'(0);
            3'd3: r = (x < y) ? W'(1) : W'(0);
            3'd4: r = x ^ y;
            3'd5: r = (f7 == 7'h20 && x[W-1]) ? ((x >> sh) | ~(ones >> sh)) : (x >> sh);
            3'd6: r = x | y;
            default: r = x & y;
        endcase
        return {1'b0, r};
    endfunction

    task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic bound_fail(string tag);
        checks++;
        errors++;
        $error("FAIL %s: observed timeout expected completion", tag);
    endtask

    // One clock: check outputs mid-cycle, account transfers, then step past the edge.
    task automatic tick();
        logic         exp_ir;
        logic         exp_ov;
        logic [W:0]   m;
        @(negedge clk);
        exp_ir = (exp_q.size() < 2) || out_ready;
        exp_ov = 1'b0;
        if (exp_q.size() > 0) exp_ov = (edge_cnt > acc_q[0]);
        chk("in_ready", W'(in_ready), W'(exp_ir));
        chk("out_valid", W'(out_valid), W'(exp_ov));
        if (stall_prev) begin
            chk("hold_result", result, held_res);
            chk("hold_illegal", W'(illegal), W'(held_ill));
        end
        if (out_valid && out_ready && exp_q.size() > 0) begin
            chk("result", result, exp_q.pop_front());
            chk("illegal", W'(illegal), W'(ill_q.pop_front()));
            void'(acc_q.pop_front());
        end
        stall_prev = out_valid && !out_ready;
        held_res   = result;
        held_ill   = illegal;
        last_fire  = in_valid && in_ready;
        if (last_fire) begin
            m = model(X, Y, funct3, funct7);
            exp_q.push_back(ovr ? ovr_res : m[W-1:0]);
            ill_q.push_back(ovr ? ovr_ill : m[W]);
            acc_q.push_back(edge_cnt + 1);
        end
        @(posedge clk);
        edge_cnt++;
        #1;
    endtask

    task automatic send(logic [W-1:0] x, logic [W-1:0] y, logic [2:0] f3, logic [6:0] f7);
        X = x; Y = y; funct3 = f3; funct7 = f7;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (last_fire) break;
        end
        if (!last_fire) bound_fail("accept_timeout");
        in_valid = 1'b0;
    endtask

    task automatic send_exp(logic [W-1:0] x, logic [W-1:0] y, logic [2:0] f3, logic [6:0] f7,
                            logic [W-1:0] r, logic il);
        ovr = 1'b1; ovr_res = r; ovr_ill = il;
        send(x, y, f3, f7);
        ovr = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        chk("drain_empty", W'(exp_q.size()), W'(0));
    endtask

    task automatic clear_model();
        exp_q.delete();
        ill_q.delete();
        acc_q.delete();
        stall_prev = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        int  idx;
        bit  pending;
        int  sel;

        // Reset and idle
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        X = '0; Y = '0; funct3 = '0; funct7 = '0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_result", result, '0);
            chk("rst_illegal", W'(illegal), W'(0));
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Directed operations
        send_exp(32'h00000001, 32'h00000002, 3'b110, 7'h00, 32'h00000003, 1'b0);
        drain();
        send_exp(32'h55555555, 32'hAAAAAAAA, 3'b100, 7'h00, 32'hFFFFFFFF, 1'b0);
        send_exp(32'h00000000, 32'h00000001, 3'b000, 7'h20, 32'hFFFFFFFF, 1'b0);
        send_exp(32'hFFFFFFFF, 32'h00000001, 3'b000, 7'h00, 32'h00000000, 1'b0);
        send_exp(32'hFFFFFFFF, 32'h00000001, 3'b010, 7'h00, 32'h00000001, 1'b0);
        send_exp(32'hFFFFFFFF, 32'h00000001, 3'b011, 7'h00, 32'h00000000, 1'b0);
        send_exp(32'h12345678, 32'h00000000, 3'b110, 7'h20, 32'h00000000, 1'b1);
        send_exp(32'h12345678, 32'h00000000, 3'b000, 7'h01, 32'h00000000, 1'b1);
`ifdef R_ALU_SHIFT_EN
        send_exp(32'h80000000, 32'h00000024, 3'b101, 7'h20, 32'hF8000000, 1'b0);
        send_exp(32'h80000000, 32'h00000024, 3'b101, 7'h00, 32'h08000000, 1'b0);
        send_exp(32'h00000001, 32'h0000001F, 3'b001, 7'h00, 32'h80000000, 1'b0);
`else
        send_exp(32'h80000000, 32'h00000024, 3'b101, 7'h20, 32'h00000000, 1'b1);
        send_exp(32'h80000000, 32'h00000024, 3'b101, 7'h00, 32'h00000000, 1'b1);
        send_exp(32'h00000001, 32'h0000001F, 3'b001, 7'h00, 32'h00000000, 1'b1);
`endif
        drain();

        // Backpressure: four ANDs with the consumer stalled for three cycles
        idx = 0; pending = 1'b0;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (idx < 4) begin
                if (!pending) begin
                    X = $urandom; Y = $urandom; funct3 = 3'b111; funct7 = 7'h00;
                    pending = 1'b1;
                end
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = (cyc >= 3);
            tick();
            if (last_fire) begin
                idx++;
                pending = 1'b0;
            end
            if (cyc == 2) chk("bp_accepted", W'(idx), W'(2));
            if (idx == 4 && exp_q.size() == 0) break;
        end
        chk("bp_all_issued", W'(idx), W'(4));
        drain();

        // Mid-operation reset discards both in-flight ops
        out_ready = 1'b0;
        send(32'h0000000F, 32'h000000F0, 3'b110, 7'h00);
        send(32'h00000003, 32'h00000005, 3'b000, 7'h00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_model();
        out_ready = 1'b1;
        chk("post_rst_out_valid", W'(out_valid), W'(0));
        for (int i = 0; i < 6; i++) tick();

        // Random traffic with random backpressure
        pending = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!pending) begin
                X = $urandom; Y = $urandom;
                funct3 = 3'($urandom_range(0, 7));
                sel = $urandom_range(0, 3);
                funct7 = (sel < 2) ? 7'h00 : (sel == 2) ? 7'h20 : 7'($urandom_range(0, 127));
                in_valid = ($urandom_range(0, 9) < 7);
                pending = in_valid;
            end
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
            if (last_fire) pending = 1'b0;
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/r_alu_pipe.md
# r_alu_pipe

Parametrised, two-stage pipelined R-format ALU that generalises the single-function 32-bit logic blocks (and/or) into one unit executing all eight RV32I R-type operations at configurable width. Operands enter through a valid/ready handshake, a result leaves two cycles later through a second valid/ready handshake, and full backpressure is supported. The block sits between the register-file read stage and writeback in the KLP32 datapath.

## Interface
- WIDTH, 32, operand/result width; power of two, 8..64.
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and opcode are valid this cycle.
- in_ready  output  1  block accepts the operation this cycle.
- X  input  WIDTH  operand rs1.
- Y  input  WIDTH  operand rs2.
- funct3  input  3  RV32I funct3.
- funct7  input  7  RV32I funct7.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result this cycle.
- result  output  WIDTH  operation result.
- illegal  output  1  opcode was not a legal R-type encoding; qualified by out_valid.

## Operation
- Transfer occurs on a cycle where valid && ready on that interface.
- Stage 1 (S1) registers X, Y, funct3, funct7 on input transfer. Stage 2 (S2) registers computed result and illegal.
- funct3 map: 000 ADD (funct7=0000000) / SUB (0100000); 001 SLL; 010 SLT (signed); 011 SLTU; 100 XOR; 101 SRL (0000000) / SRA (0100000); 110 OR; 111 AND.
- funct7 legal only as 0000000, or 0100000 with funct3 000/101. Any other combination: illegal=1, result=0.
- Arithmetic modulo 2^WIDTH; carry/overflow discarded. SLT/SLTU yield 1 or 0, zero-extended to WIDTH.
- Shift amount = Y[SHW-1:0]; upper Y bits ignored. SRA replicates X[WIDTH-1].
- S1 advances into S2 when S2 is empty or S2 transfers out this cycle. in_ready = !S1_valid || S1 advancing (combinational from out_ready).
- Data in a stalled stage holds stable; result/illegal do not change while out_valid && !out_ready.

## Timing
- Reset: S1_valid=0, S2_valid=0, out_valid=0, in_ready=1, result=0, illegal=0. Reset wins over any simultaneous transfer; in-flight operations discarded.
- Latency: input transfer at edge N -> out_valid at edge N+2 (no stall).
- Throughput: one operation per cycle while out_ready=1.
- Capacity: two operations in flight. Both stages full and out_ready=0 -> in_ready=0.
- Simultaneous output transfer and input transfer while full: S2 loads from S1, S1 loads the new operands; no bubble, no loss.
- out_valid never deasserts without a transfer except on reset.

## Configuration
- R_ALU_SHIFT_EN defined: SLL/SRL/SRA implemented as above.
- Not defined: funct3 001 and 101 are treated as illegal (illegal=1, result=0); shifter logic absent. All other ops and timing unchanged.

## Test plan
- Reset then idle: out_valid=0, in_ready=1, result=0 for 5 cycles; after rst deasserts in_ready stays 1.
- WIDTH=32, out_ready=1: X=0x00000001,Y=0x00000002,OR -> result 0x00000003 two cycles later; X=0x55555555,Y=0xAAAAAAAA,XOR -> 0xFFFFFFFF; SUB 0-1 -> 0xFFFFFFFF; SLT X=0xFFFFFFFF,Y=1 -> 1; SLTU same -> 0.
- Shifts (macro on): SRA X=0x80000000,Y=0x00000024 -> 0xF8000000 (shamt=4); SLL X=1,Y=31 -> 0x80000000. Macro off: same inputs -> illegal=1, result=0.
- Illegal: funct3=110, funct7=0100000 -> illegal=1, result=0.
- Backpressure: stream 4 ANDs back-to-back, out_ready=0 for 3 cycles -> in_ready drops after 2 accepted, result stable, all 4 results emerge in order, none lost or duplicated.
- Mid-operation reset: two ops in flight, rst=1 for one cycle -> out_valid=0 next cycle, neither result ever appears.
